ab_xor_arbiter: RTL
===================

Name: ab_xor_arbiter

Overview:
Shares one pipelined (A+B)^C datapath among NREQ requesters. A round-robin arbiter grants at most one requester per cycle and captures that requester's operands. Each operation travels down the shared pipe with its requester ID. The result returns on a common response bus tagged with that ID. The block sits between client blocks and the arithmetic pipe, so each client does not need its own adder/XOR.

Parameters:
WIDTH, 4, operand and result width in bits
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  NREQ  per-requester request, level; operands valid while high
a_in  input  NREQ*WIDTH  packed A operands, requester i at bits [i*WIDTH +: WIDTH]
b_in  input  NREQ*WIDTH  packed B operands, same packing
c_in  input  NREQ*WIDTH  packed C operands, same packing
hold  input  1  freeze: no grants and the pipe does not advance
gnt  output  NREQ  one-hot grant, combinational, same cycle as req
rsp_valid  output  1  response valid, one-cycle pulse per operation
rsp_id  output  IDW  requester index of the current response
rsp_q  output  WIDTH  result ((A+B) mod 2**WIDTH) ^ C
busy  output  1  high while any pipe stage holds a valid operation

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valids, rsp_valid, rsp_id, rsp_q and busy go to 0.
  - Round-robin pointer goes to NREQ-1, so requester 0 has top priority first.
  - gnt is forced to 0 while rst=1.
  - Reset in mid-operation discards all in-flight results; they are never issued.
- Grant:
  - gnt is 0 when hold=1 or req=0.
  - Otherwise gnt is one-hot: the first requester with req high, searching from ptr+1 upward with wrap.
  - A handshake occurs on any edge where req[i] & gnt[i]. That edge captures a_in/b_in/c_in slice i and ID i into stage 1.
  - ptr updates to i on a handshake only.
  - A requester holds req and its operands until it sees gnt. After a handshake it may drop req or present new operands.
- Pipe, 3 stages, each with a valid bit and an ID:
  - S1 registers A, B, C.
  - S2 registers sum = S1.A + S1.B (carry dropped, WIDTH bits) and carries C forward.
  - S3 registers rsp_q = S2.sum ^ S2.C.
  - rsp_valid is S3 valid; rsp_id is S3 ID.
- Latency: a handshake at edge k gives rsp_valid=1 in the cycle after edge k+2. That is 3 edges with hold=0.
- Throughput: one operation per cycle, with no bubbles while requests are continuous.
- hold=1:
  - All stage registers keep their values.
  - rsp_valid stays at its current value. Outputs are frozen, so a response visible during hold is the same response and is consumed once, when hold releases.
  - No new grants are issued.
- Invalid stages:
  - Data registers of an invalid stage may still update.
  - rsp_q and rsp_id are don't-care when rsp_valid=0.
- busy = OR of the S1, S2 and S3 valids.
- Simultaneous events:
  - rst has priority over hold, and hold has priority over req.
  - Requests that are granted go only to the granted requester. A request that stays high but is not granted is served in a later cycle under round-robin.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN
- Defined: fixed priority. The lowest index with req high wins. ptr is not implemented.
- Undefined (default): round-robin as described above.
- Latency, handshake and hold behaviour are identical in both builds.

Decomposition:
- Package ab_xor_arb_pkg:
  - Default WIDTH/NREQ/IDW localparams.
  - Stage struct typedef {valid, id, a, b, c}.
  - Function for round-robin one-hot select.
- One sub-module, ab_xor_pipe: the 3-stage datapath with valid and ID sideband and the hold enable. The arbiter and ptr stay in the top level.

Test Plan:
- Single operation: after reset, req=4'b0001 with A=3, B=5, C=6 → gnt=0001 the same cycle. 3 edges later rsp_valid=1, rsp_id=0, rsp_q=4'hE. busy=1 during the flight only.
- Overflow: A=4'hF, B=4'h2, C=4'h0 on requester 2 → rsp_q=4'h1, rsp_id=2.
- Round-robin: req=4'b1111 held for 8 cycles → grant order 0,1,2,3,0,1,2,3. rsp_valid is continuous, with IDs in the same order and 3 cycles later.
- Hold: assert hold for 2 cycles with 3 operations in flight → gnt=0 and outputs frozen. After release, the remaining responses appear in order, each exactly once.
- Reset mid-flight: rst=1 one cycle after 2 handshakes → no rsp_valid follows and busy=0. The next grant with req=4'b1010 goes to requester 1.
- With ARB_FIXED_PRIO_EN: req=4'b0011 held → requester 0 is always granted and requester 1 is granted only after req[0] drops.

Source files
------------

// File: rtl/ab_xor_arb_pkg.sv
// Shared types and helpers for the (A+B)^C arbiter slice.
// Build option: define ARB_FIXED_PRIO_EN for a fixed-priority arbiter (lowest index wins).
package ab_xor_arb_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NREQ_DEF  = 4;
    localparam int IDW_DEF   = 2;

    // Upper bound on requesters; the select helper works on this fixed width.
    localparam int MAX_REQ   = 8;
    localparam int SELW      = 3;

    // Layout of one pipe stage at the default configuration.
    typedef struct packed {
        logic                 valid;
        logic [IDW_DEF-1:0]   id;
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
        logic [WIDTH_DEF-1:0] c;
    } stage_t;

    // One-hot pick of the first set req bit, searching from ptr+1 upward and
    // wrapping at n. Passing ptr = n-1 gives plain lowest-index priority.
    function automatic logic [MAX_REQ-1:0] rr_onehot(input logic [MAX_REQ-1:0] req,
                                                     input int ptr, input int n);
        logic [MAX_REQ-1:0] g;
        logic               found;
        int                 idx;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (ptr + k) % n;
            if (k <= n && !found && req[idx[SELW-1:0]]) begin
                g[idx[SELW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/ab_xor_pipe.sv
// Three-stage (A+B)^C datapath with valid/ID sideband. hold freezes every
// stage, so a response sitting on the output is presented unchanged until
// the pipe advances again.
module ab_xor_pipe
    import ab_xor_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDW   = IDW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             in_valid,
    input  logic [IDW-1:0]   in_id,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    output logic [IDW-1:0]   out_id,
    output logic [WIDTH-1:0] out_q,
    output logic             busy
);

    // Valid and ID travel as shift registers, index = stage number.
    logic [3:1]            vld_q, vld_d;
    logic [3:1][IDW-1:0]   id_q,  id_d;
    logic [WIDTH-1:0]      a1_q, a1_d, b1_q, b1_d, c1_q, c1_d;
    logic [WIDTH-1:0]      sum2_q, sum2_d, c2_q, c2_d;
    logic [WIDTH-1:0]      q3_q, q3_d;

    // Next-state: shift everything one stage unless frozen. Data of invalid
    // stages is allowed to move; only the valid bits matter downstream.
    always_comb begin
        vld_d  = vld_q;
        id_d   = id_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        c1_d   = c1_q;
        sum2_d = sum2_q;
        c2_d   = c2_q;
        q3_d   = q3_q;
        if (!hold) begin
            vld_d  = {vld_q[2:1], in_valid};
            id_d   = {id_q[2:1], in_id};
            a1_d   = in_a;
            b1_d   = in_b;
            c1_d   = in_c;
            sum2_d = a1_q + b1_q;          // carry out is dropped
            c2_d   = c1_q;
            q3_d   = sum2_q ^ c2_q;
        end
    end

    // Stage registers; reset clears valids and the visible response.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            id_q   <= '0;
            a1_q   <= '0;
            b1_q   <= '0;
            c1_q   <= '0;
            sum2_q <= '0;
            c2_q   <= '0;
            q3_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            id_q   <= id_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            c1_q   <= c1_d;
            sum2_q <= sum2_d;
            c2_q   <= c2_d;
            q3_q   <= q3_d;
        end
    end

    assign out_valid = vld_q[3];
    assign out_id    = id_q[3];
    assign out_q     = q3_q;
    assign busy      = |vld_q;

endmodule

// File: rtl/ab_xor_arbiter.sv
// Round-robin front end sharing one (A+B)^C pipe among NREQ requesters.
// Build option: ARB_FIXED_PRIO_EN selects fixed lowest-index priority and
// removes the round-robin pointer.
module ab_xor_arbiter
    import ab_xor_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = IDW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    input  logic [NREQ*WIDTH-1:0] c_in,
    input  logic                  hold,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_q,
    output logic                  busy
);

    logic [NREQ-1:0]  sel;
    logic             hs;
    logic [IDW-1:0]   hs_id;
    logic [WIDTH-1:0] a_sel, b_sel, c_sel;

`ifdef ARB_FIXED_PRIO_EN
    // Search always starts at index 0.
    always_comb sel = NREQ'(rr_onehot(MAX_REQ'(req), NREQ - 1, NREQ));
`else
    logic [IDW-1:0] ptr_q, ptr_d;

    // Search starts just above the last requester served.
    always_comb sel = NREQ'(rr_onehot(MAX_REQ'(req), int'(ptr_q), NREQ));

    // Pointer follows the winner, only on an actual handshake.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) ptr_d = hs_id;
    end

    // Pointer register; reset leaves requester 0 at top priority.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= IDW'(NREQ - 1);
        else     ptr_q <= ptr_d;
    end
`endif

    // Grant is combinational; reset and hold both suppress it.
    always_comb gnt = (rst || hold) ? '0 : sel;

    // Encode the handshake and steer the winner's operand slices.
    always_comb begin
        hs    = 1'b0;
        hs_id = '0;
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && gnt[i]) begin
                hs    = 1'b1;
                hs_id = IDW'(i);
                a_sel = a_in[i*WIDTH +: WIDTH];
                b_sel = b_in[i*WIDTH +: WIDTH];
                c_sel = c_in[i*WIDTH +: WIDTH];
            end
        end
    end

    ab_xor_pipe #(
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .in_valid  (hs),
        .in_id     (hs_id),
        .in_a      (a_sel),
        .in_b      (b_sel),
        .in_c      (c_sel),
        .out_valid (rsp_valid),
        .out_id    (rsp_id),
        .out_q     (rsp_q),
        .busy      (busy)
    );

endmodule
